image_read_sequencer: RTL and testbench

//   Frame-timing controller for the image read datapath: sequences start-up delay,

---
 rtl/image_read_sequencer.sv | 140 ++++++++++++++
 tb/tb_image_read_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_read_sequencer.sv
// Frame-timing controller for the image read datapath: start-up delay, vertical pulse,
// per-row horizontal blanking and back-pressured pixel-pair address generation.
module image_read_sequencer #(
    parameter int IMAGE_WIDTH           = 768,
    parameter int IMAGE_HEIGHT          = 512,
    parameter int START_DELAY           = 100,
    parameter int HORIZONTAL_SYNC_DELAY = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ready,
    output logic        vertical_Pulse,
    output logic        horizontal_Pulse,
    output logic [9:0]  row,
    output logic [10:0] column,
    output logic        pixel_Valid,
    output logic        busy,
    output logic        done_Flag
);

    localparam int VS_W = $clog2(START_DELAY + 1);
    localparam int HS_W = $clog2(HORIZONTAL_SYNC_DELAY + 1);

    localparam logic [VS_W-1:0] VS_LAST  = VS_W'(START_DELAY - 1);
    localparam logic [VS_W-1:0] VS_ONE   = VS_W'(1);
    localparam logic [HS_W-1:0] HS_LAST  = HS_W'(HORIZONTAL_SYNC_DELAY - 1);
    localparam logic [HS_W-1:0] HS_ONE   = HS_W'(1);
    localparam logic [10:0]     COL_LAST = 11'(IMAGE_WIDTH - 2);
    localparam logic [9:0]      ROW_LAST = 10'(IMAGE_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VSYNC = 3'd1,
        S_HSYNC = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q;
    logic [VS_W-1:0] vs_cnt_q;
    logic [HS_W-1:0] hs_cnt_q;
    logic [9:0]      row_q;
    logic [10:0]     column_q;
    logic            vpulse_q;
    logic            hpulse_q;
    logic            busy_q;
    logic            done_q;

    // A transfer happens whenever the active row phase meets downstream ready.
    assign pixel_Valid      = (state_q == S_DATA) & ready;
    assign vertical_Pulse   = vpulse_q;
    assign horizontal_Pulse = hpulse_q;
    assign row              = row_q;
    assign column           = column_q;
    assign busy             = busy_q;
    assign done_Flag        = done_q;

    // Frame sequencer: state, delay counters, addresses and the registered phase outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            vs_cnt_q <= '0;
            hs_cnt_q <= '0;
            row_q    <= '0;
            column_q <= '0;
            vpulse_q <= 1'b0;
            hpulse_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_VSYNC;
                        vs_cnt_q <= '0;
                        vpulse_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_VSYNC: begin
                    if (vs_cnt_q == VS_LAST) begin
                        state_q  <= S_HSYNC;
                        vs_cnt_q <= '0;
                        hs_cnt_q <= '0;
                        vpulse_q <= 1'b0;
                    end else begin
                        vs_cnt_q <= vs_cnt_q + VS_ONE;
                    end
                end
                S_HSYNC: begin
                    if (hs_cnt_q == HS_LAST) begin
                        state_q  <= S_DATA;
                        hs_cnt_q <= '0;
                        hpulse_q <= 1'b1;
                    end else begin
                        hs_cnt_q <= hs_cnt_q + HS_ONE;
                    end
                end
                S_DATA: begin
                    // Without ready the current pair is simply held; there is no timeout.
                    if (ready) begin
                        if (column_q != COL_LAST) begin
                            column_q <= column_q + 11'd2;
                        end else begin
                            column_q <= '0;
                            hpulse_q <= 1'b0;
                            if (row_q != ROW_LAST) begin
                                row_q   <= row_q + 10'd1;
                                state_q <= S_HSYNC;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    row_q    <= '0;
                    column_q <= '0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    vs_cnt_q <= '0;
                    hs_cnt_q <= '0;
                    row_q    <= '0;
                    column_q <= '0;
                    vpulse_q <= 1'b0;
                    hpulse_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_read_sequencer.sv
// Scoreboard bench for image_read_sequencer: a small frame config plus a 1x2 frame instance,
// with constant, toggling and random ready.
module tb_image_read_sequencer;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int SD  = 3;
    localparam int HSD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        ready = 1'b1;
    int          rmode = 0;

    logic        vp, hp, pv, busy, done;
    logic [9:0]  row;
    logic [10:0] column;
    logic        vp2, hp2, pv2, busy2, done2;
    logic [9:0]  row2;
    logic [10:0] col2;

    int n_checks = 0;
    int n_pass   = 0;
    int pv2_cnt  = 0;
    int done2_cnt = 0;

    // expected stream: {is_done, row, column}
    logic [21:0] exp_q[$];

    image_read_sequencer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .START_DELAY(SD),
                           .HORIZONTAL_SYNC_DELAY(HSD)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .vertical_Pulse(vp), .horizontal_Pulse(hp), .row(row), .column(column),
        .pixel_Valid(pv), .busy(busy), .done_Flag(done));

    image_read_sequencer #(.IMAGE_WIDTH(2), .IMAGE_HEIGHT(1), .START_DELAY(SD),
                           .HORIZONTAL_SYNC_DELAY(HSD)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .ready(ready),
        .vertical_Pulse(vp2), .horizontal_Pulse(hp2), .row(row2), .column(col2),
        .pixel_Valid(pv2), .busy(busy2), .done_Flag(done2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference timing: {busy, vertical, horizontal, done} k cycles after VSYNC entry, ready=1.
    function automatic logic [3:0] exp_phase(int k, int sd, int h, int hsd, int w);
        int row_len = hsd + w / 2;
        int tot     = sd + h * row_len;
        int rel     = k - sd;
        logic v  = (k < sd);
        logic hh = (k >= sd) && (rel < h * row_len) && ((rel % row_len) >= hsd);
        logic d  = (k == tot);
        logic b  = (k <= tot);
        return {b, v, hh, d};
    endfunction

    task automatic push_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c += 2)
                exp_q.push_back({1'b0, 10'(r), 11'(c)});
        exp_q.push_back({1'b1, 21'd0});
    endtask

    task automatic launch(input bit hold);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 if (!hold) start = 1'b0;
    endtask

    // Checks every cycle of one frame from VSYNC entry up to the done cycle.
    task automatic frame_timing(input string name, input int drop_at);
        for (int k = 0; k <= SD + H * (HSD + W / 2); k++) begin
            @(negedge clk);
            chk(name, {busy, vp, hp, done}, exp_phase(k, SD, H, HSD, W));
            if (k == drop_at) start = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int cyc = 0;
        bit got = 1'b0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
        end
        chk(name, got, 1'b1);
    endtask

    // Ready driver: constant, toggling or random, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = ~ready;
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every transfer and every done pulse.
    logic        prev_hp = 1'b0, prev_rdy = 1'b1;
    logic [20:0] prev_addr = '0;
    logic [21:0] e;
    always @(negedge clk) begin
        if (pv) begin
            if (exp_q.size() == 0) chk("pv_unexpected", 32'd1, 32'd0);
            else begin e = exp_q.pop_front(); chk("pv_pair", {1'b0, row, column}, e); end
            chk("pv_in_data", hp, 1'b1);
        end
        if (done) begin
            if (exp_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
            else begin e = exp_q.pop_front(); chk("done_order", {1'b1, 21'd0}, e); end
        end
        if (hp && prev_hp && !prev_rdy) chk("hold_addr", {row, column}, prev_addr);
        prev_hp   = hp;
        prev_rdy  = ready;
        prev_addr = {row, column};
    end

    // Monitor for the single-pair frame instance.
    always @(negedge clk) begin
        if (pv2) begin
            pv2_cnt++;
            chk("s6_pair", {row2, col2}, 32'd0);
        end
        if (done2) done2_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset then idle with start low
        #3 reset = 1'b0;
        #1 chk("reset_outputs", {vp, hp, row, column, pv, busy, done}, 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", {vp, hp, row, column, pv, busy, done}, 32'd0);
        end

        // 2: single frame, ready tied high, full cycle-by-cycle timing
        rmode = 0;
        push_frame();
        launch(1'b0);
        frame_timing("s2_timing", -1);
        @(negedge clk);
        chk("s2_idle", {busy, vp, hp, done}, 32'd0);
        chk("s2_drained", exp_q.size(), 32'd0);

        // 3: ready toggling every cycle
        rmode = 1;
        push_frame();
        launch(1'b0);
        wait_done("s3_done", 400);
        repeat (3) @(negedge clk);
        chk("s3_drained", exp_q.size(), 32'd0);
        chk("s3_idle", busy, 1'b0);

        // 4: reset mid-frame at row 2 column 4, then a clean random-ready frame
        rmode = 0;
        push_frame();
        launch(1'b0);
        begin
            int cyc = 0;
            bit hit = 1'b0;
            while (!hit && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (pv && row == 10'd2 && column == 11'd4) hit = 1'b1;
            end
            chk("s4_reach_2_4", hit, 1'b1);
        end
        #2 reset = 1'b0;
        #1 chk("s4_async_clear", {vp, hp, row, column, pv, busy, done}, 32'd0);
        exp_q.delete();
        repeat (4) @(negedge clk);
        chk("s4_held_idle", {vp, hp, row, column, pv, busy, done}, 32'd0);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("s4_no_restart", busy, 1'b0);
        rmode = 2;
        push_frame();
        launch(1'b0);
        wait_done("s4_clean_done", 2000);
        repeat (3) @(negedge clk);
        chk("s4_drained", exp_q.size(), 32'd0);

        // 5: start held high gives back-to-back frames, start ignored mid-frame
        rmode = 0;
        push_frame();
        push_frame();
        launch(1'b1);
        frame_timing("s5_frame1", -1);
        @(negedge clk);
        chk("s5_gap_idle", {busy, vp, hp, done}, 32'd0);
        frame_timing("s5_frame2", 5);
        @(negedge clk);
        chk("s5_end_idle", {busy, vp, hp, done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("s5_stays_idle", busy, 1'b0);
        chk("s5_drained", exp_q.size(), 32'd0);

        // 6: one-row, two-pixel frame
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int k = 0; k <= SD + 1 * (HSD + 1); k++) begin
            @(negedge clk);
            chk("s6_timing", {busy2, vp2, hp2, done2}, exp_phase(k, SD, 1, HSD, 2));
        end
        @(negedge clk);
        chk("s6_idle", {busy2, vp2, hp2, done2, row2, col2}, 32'd0);
        chk("s6_pv_count", pv2_cnt, 32'd1);
        chk("s6_done_count", done2_cnt, 32'd1);
        chk("s6_main_quiet", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
